// File: rtl/sensor_pwr_pkg.sv
// Shared constants and rail decode for the thermal-sensor power sequencer.
package sensor_pwr_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RAMP_UP   = 2'd1;
  localparam logic [1:0] ON        = 2'd2;
  localparam logic [1:0] RAMP_DOWN = 2'd3;

  localparam logic [2:0] L_OFF   = 3'd0;
  localparam logic [2:0] L_IO    = 3'd1;
  localparam logic [2:0] L_CORE  = 3'd2;
  localparam logic [2:0] L_BOOST = 3'd3;
  localparam logic [2:0] L_BIAS  = 3'd4;
  localparam logic [2:0] L_RUN   = 3'd5;

  typedef struct packed {
    logic io;
    logic core;
    logic boost;
    logic bias;
    logic run;
  } rails_t;

  // Each rail stays on for every level at or above the step that enabled it.
  function automatic rails_t decode_level(input logic [2:0] lvl);
    rails_t r;
    r.io    = (lvl >= L_IO);
    r.core  = (lvl >= L_CORE);
    r.boost = (lvl >= L_BOOST);
    r.bias  = (lvl >= L_BIAS);
    r.run   = (lvl == L_RUN);
    return r;
  endfunction

endpackage

// File: rtl/sensor_pwr_seq.sv
// Ordered power-up / reverse power-down of the sensor rails with programmable
// dwell times and a latched fault shutdown.
module sensor_pwr_seq
  import sensor_pwr_pkg::*;
#(
  parameter int DLY_UP = 100000,
  parameter int DLY_DN = 10000,
  parameter int CNT_W  = 24
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       pwr_req,
  input  logic       bias_hv_req,
  input  logic       fault,
  input  logic       fault_clr,
  output logic       sensor_io_pwr_ena_n,
  output logic       sensor_core_pwr_ena,
  output logic       sensor_bias_boost_pwr_ena,
  output logic       sensor_bias_pwr_ena,
  output logic       sensor_bias_volt_sel,
  output logic       sensor_ena,
  output logic [2:0] level,
  output logic       pwr_good,
  output logic       busy,
  output logic       fault_flag
);

  localparam logic [CNT_W-1:0] RELOAD_UP = CNT_W'(DLY_UP - 1);
  localparam logic [CNT_W-1:0] RELOAD_DN = CNT_W'(DLY_DN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state, nxt_state;
  logic [2:0]       nxt_level;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  rails_t           nxt_rails;
  logic             stop;

  assign stop      = ~pwr_req | fault;
  assign nxt_rails = decode_level(nxt_level);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    nxt_state = state;
    nxt_level = level;
    nxt_cnt   = (cnt != '0) ? cnt - CNT_ONE : cnt;
    case (state)
      IDLE: begin
        if (pwr_req && !fault_flag && !fault) begin
          nxt_level = L_IO;
          nxt_cnt   = RELOAD_UP;
          nxt_state = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (stop) begin
          // The step just reached is withdrawn right away.
          nxt_level = level - 3'd1;
          nxt_cnt   = (level == L_IO) ? '0 : RELOAD_DN;
          nxt_state = (level == L_IO) ? IDLE : RAMP_DOWN;
        end else if (cnt == '0) begin
          nxt_level = level + 3'd1;
          nxt_cnt   = RELOAD_UP;
          if (level == L_BIAS) nxt_state = ON;
        end
      end
      ON: begin
        if (stop) begin
          nxt_level = L_BIAS;
          nxt_cnt   = RELOAD_DN;
          nxt_state = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        // pwr_req is deliberately ignored so a power-down always completes.
        if (cnt == '0) begin
          nxt_level = level - 3'd1;
          nxt_cnt   = (level == L_IO) ? '0 : RELOAD_DN;
          if (level == L_IO) nxt_state = IDLE;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_level = L_OFF;
        nxt_cnt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (srst) begin
      state                     <= IDLE;
      level                     <= L_OFF;
      cnt                       <= '0;
      fault_flag                <= 1'b0;
      sensor_io_pwr_ena_n       <= 1'b1;
      sensor_core_pwr_ena       <= 1'b0;
      sensor_bias_boost_pwr_ena <= 1'b0;
      sensor_bias_pwr_ena       <= 1'b0;
      sensor_bias_volt_sel      <= 1'b0;
      sensor_ena                <= 1'b0;
      pwr_good                  <= 1'b0;
      busy                      <= 1'b0;
    end else begin
      state                     <= nxt_state;
      level                     <= nxt_level;
      cnt                       <= nxt_cnt;
      fault_flag                <= fault | (fault_flag & ~fault_clr);
      sensor_io_pwr_ena_n       <= ~nxt_rails.io;
      sensor_core_pwr_ena       <= nxt_rails.core;
      sensor_bias_boost_pwr_ena <= nxt_rails.boost;
      sensor_bias_pwr_ena       <= nxt_rails.bias;
      sensor_ena                <= nxt_rails.run;
      pwr_good                  <= (nxt_state == ON);
      busy                      <= (nxt_state == RAMP_UP) || (nxt_state == RAMP_DOWN);
      // Bias voltage is only allowed to change while the bias rail is unloaded.
      if (level < L_BIAS) sensor_bias_volt_sel <= bias_hv_req;
    end
  end

endmodule

// File: tb/tb_sensor_pwr_seq.sv
// Directed bench for sensor_pwr_seq: timestamp-based reference model compared
// every cycle, plus literal expectations at the documented milestones.
module tb_sensor_pwr_seq;

  localparam int DLY_UP = 4;
  localparam int DLY_DN = 2;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic pwr_req = 1'b0;
  logic bias_hv_req = 1'b0;
  logic fault = 1'b0;
  logic fault_clr = 1'b0;

  logic       io_n, core_en, boost_en, bias_en, vsel, sens_en;
  logic [2:0] level;
  logic       pwr_good, busy, fault_flag;

  always #5 clk = ~clk;

  sensor_pwr_seq #(.DLY_UP(DLY_UP), .DLY_DN(DLY_DN), .CNT_W(8)) dut (
    .clk                       (clk),
    .srst                      (srst),
    .pwr_req                   (pwr_req),
    .bias_hv_req               (bias_hv_req),
    .fault                     (fault),
    .fault_clr                 (fault_clr),
    .sensor_io_pwr_ena_n       (io_n),
    .sensor_core_pwr_ena       (core_en),
    .sensor_bias_boost_pwr_ena (boost_en),
    .sensor_bias_pwr_ena       (bias_en),
    .sensor_bias_volt_sel      (vsel),
    .sensor_ena                (sens_en),
    .level                     (level),
    .pwr_good                  (pwr_good),
    .busy                      (busy),
    .fault_flag                (fault_flag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: level plus the absolute edge index at which the next step is due.
  typedef enum int {OFF, RISING, FULL, FALLING} mode_t;
  mode_t m_mode  = OFF;
  int    m_level = 0;
  int    m_due   = 0;
  int    edge_no = 0;
  bit    m_flag  = 1'b0;
  bit    m_vsel  = 1'b0;
  bit    started = 1'b0;

  always @(posedge clk) begin : model
    int old_level;
    bit quit;
    old_level = m_level;
    quit      = !pwr_req || fault;
    if (srst) begin
      m_mode = OFF; m_level = 0; m_flag = 1'b0; m_vsel = 1'b0;
    end else begin
      case (m_mode)
        OFF:
          if (pwr_req && !m_flag && !fault) begin
            m_level = 1; m_due = edge_no + DLY_UP; m_mode = RISING;
          end
        RISING:
          if (quit) begin
            m_level = m_level - 1;
            m_due   = edge_no + DLY_DN;
            m_mode  = (m_level == 0) ? OFF : FALLING;
          end else if (edge_no == m_due) begin
            m_level = m_level + 1;
            m_due   = edge_no + DLY_UP;
            if (m_level == 5) m_mode = FULL;
          end
        FULL:
          if (quit) begin
            m_level = 4; m_due = edge_no + DLY_DN; m_mode = FALLING;
          end
        FALLING:
          if (edge_no == m_due) begin
            m_level = m_level - 1;
            m_due   = edge_no + DLY_DN;
            if (m_level == 0) m_mode = OFF;
          end
        default: m_mode = OFF;
      endcase
      if (old_level < 4) m_vsel = bias_hv_req;
      if (fault) m_flag = 1'b1;
      else if (fault_clr) m_flag = 1'b0;
    end
    edge_no++;
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("level",      level,      m_level);
      check("io_n",       io_n,       m_level < 1);
      check("core_en",    core_en,    m_level >= 2);
      check("boost_en",   boost_en,   m_level >= 3);
      check("bias_en",    bias_en,    m_level >= 4);
      check("sensor_ena", sens_en,    m_level == 5);
      check("pwr_good",   pwr_good,   m_mode == FULL);
      check("busy",       busy,       (m_mode == RISING) || (m_mode == FALLING));
      check("volt_sel",   vsel,       m_vsel);
      check("fault_flag", fault_flag, m_flag);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick(3);
    check("rst_io_n", io_n, 1);
    check("rst_level", level, 0);
    check("rst_sens", sens_en, 0);
    check("rst_busy", busy, 0);
    check("rst_pg", pwr_good, 0);
    check("rst_flag", fault_flag, 0);
    srst = 1'b0;
    tick(1);

    // Full ramp-up, steps every DLY_UP cycles
    pwr_req = 1'b1;
    tick(1);  check("up_c1_level", level, 1); check("up_c1_busy", busy, 1);
    tick(4);  check("up_c5_level", level, 2);
    tick(4);  check("up_c9_level", level, 3);
    tick(4);  check("up_c13_level", level, 4); check("up_c13_sens", sens_en, 0);
    tick(3);  check("up_c16_busy", busy, 1); check("up_c16_pg", pwr_good, 0);
    tick(1);  check("up_c17_level", level, 5); check("up_c17_sens", sens_en, 1);
    check("up_c17_pg", pwr_good, 1); check("up_c17_busy", busy, 0);

    // Voltage select frozen under load
    bias_hv_req = 1'b1;
    tick(3);  check("vsel_frozen", vsel, 0);

    // Power-down from ON
    pwr_req = 1'b0;
    tick(1);  check("dn_t1_level", level, 4); check("dn_t1_pg", pwr_good, 0);
    tick(2);  check("dn_t3_level", level, 3); check("dn_t3_vsel", vsel, 0);
    tick(1);  check("dn_t4_vsel", vsel, 1);
    tick(5);  check("dn_t9_level", level, 0); check("dn_t9_io_n", io_n, 1);
    check("dn_t9_busy", busy, 0);
    tick(3);

    // Abort at level 3 while the dwell counter is mid-count
    pwr_req = 1'b1;
    tick(10); check("ab_level3", level, 3);
    pwr_req = 1'b0;
    tick(1);  check("ab_t1_level", level, 2); check("ab_t1_boost", boost_en, 0);
    tick(2);  check("ab_t3_level", level, 1);
    tick(2);  check("ab_t5_level", level, 0);
    tick(2);

    // Re-request during ramp-down is ignored until IDLE
    pwr_req = 1'b1;
    tick(17); check("rr_on", level, 5);
    pwr_req = 1'b0;
    tick(2);
    pwr_req = 1'b1;
    tick(7);  check("rr_t9_level", level, 0);
    tick(1);  check("rr_t10_level", level, 1);
    tick(16); check("rr_on_again", level, 5);

    // Fault pulse in ON, latched shutdown
    fault = 1'b1;
    tick(1);  fault = 1'b0;
    check("flt_flag", fault_flag, 1); check("flt_level", level, 4);
    tick(8);  check("flt_t9_level", level, 0);
    tick(10); check("flt_held_idle", level, 0);
    fault = 1'b1; fault_clr = 1'b1;
    tick(1);  fault = 1'b0; fault_clr = 1'b0;
    check("flt_priority", fault_flag, 1);
    tick(2);  check("flt_still_idle", level, 0);
    fault_clr = 1'b1;
    tick(1);  fault_clr = 1'b0;
    check("clr_flag", fault_flag, 0); check("clr_level", level, 0);
    tick(1);  check("clr_reramp", level, 1);
    pwr_req = 1'b0;
    tick(1);  check("ab_l1_level", level, 0); check("ab_l1_busy", busy, 0);
    tick(2);

    // Fault in IDLE only sets the flag
    pwr_req = 1'b1; fault = 1'b1;
    tick(1);  fault = 1'b0;
    check("idle_flt_level", level, 0); check("idle_flt_flag", fault_flag, 1);
    pwr_req = 1'b0; fault_clr = 1'b1;
    tick(1);  fault_clr = 1'b0;
    check("idle_clr", fault_flag, 0);

    // Synchronous reset mid-ramp drops everything at once
    pwr_req = 1'b1;
    tick(10); check("srst_pre", level, 3);
    srst = 1'b1;
    tick(1);  check("srst_level", level, 0); check("srst_io_n", io_n, 1);
    check("srst_core", core_en, 0); check("srst_busy", busy, 0);
    srst = 1'b0;
    tick(1);  check("srst_restart", level, 1);

    // Fault during ramp-up
    tick(5);
    fault = 1'b1;
    tick(1);  fault = 1'b0;
    check("rufl_flag", fault_flag, 1);
    tick(10);
    fault_clr = 1'b1; pwr_req = 1'b0;
    tick(1);  fault_clr = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
